// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R1W register file, r0 hardwired to zero, per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to enable same-cycle write-through on both read ports.
module regfile_scoreboard #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             ctrl_writeEnable,
   input  logic [AW-1:0]    ctrl_writeReg,
   input  logic [WIDTH-1:0] data_writeReg,
   input  logic [AW-1:0]    ctrl_readRegA,
   input  logic [AW-1:0]    ctrl_readRegB,
   output logic [WIDTH-1:0] data_readRegA,
   output logic [WIDTH-1:0] data_readRegB,
   input  logic             issue_en,
   input  logic [AW-1:0]    issue_reg,
   output logic             busyA,
   output logic             busyB,
   output logic [AW:0]      busy_count
);

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic [AW:0]      busy_count_q;
   logic [AW:0]      busy_count_d;

   logic             wr_ok;
   logic [WIDTH-1:0] arr_a;
   logic [WIDTH-1:0] arr_b;
   logic             raw_busy_a;
   logic             raw_busy_b;

   assign wr_ok = ctrl_writeEnable && (ctrl_writeReg != '0);

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_ok) begin
         regs_d[ctrl_writeReg] = data_writeReg;
      end
      // a fresh issue outranks a same-cycle writeback: the newer producer is still pending
      for (int r = 1; r < DEPTH; r++) begin
         if (issue_en && (issue_reg == AW'(r))) begin
            busy_d[r] = 1'b1;
         end else if (ctrl_writeEnable && (ctrl_writeReg == AW'(r))) begin
            busy_d[r] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      busy_count_d = '0;
      for (int r = 0; r < DEPTH; r++) begin
         busy_count_d = busy_count_d + (AW+1)'(busy_d[r]);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         regs_q       <= '{default: '0};
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign arr_a      = (ctrl_readRegA == '0) ? '0 : regs_q[ctrl_readRegA];
   assign arr_b      = (ctrl_readRegB == '0) ? '0 : regs_q[ctrl_readRegB];
   assign raw_busy_a = (ctrl_readRegA == '0) ? 1'b0 : busy_q[ctrl_readRegA];
   assign raw_busy_b = (ctrl_readRegB == '0) ? 1'b0 : busy_q[ctrl_readRegB];
   assign busy_count = busy_count_q;

`ifdef REGFILE_BYPASS_EN
   logic hit_a;
   logic hit_b;
   logic iss_a;
   logic iss_b;

   assign hit_a = wr_ok && (ctrl_writeReg == ctrl_readRegA);
   assign hit_b = wr_ok && (ctrl_writeReg == ctrl_readRegB);
   assign iss_a = issue_en && (issue_reg == ctrl_readRegA);
   assign iss_b = issue_en && (issue_reg == ctrl_readRegB);

   assign data_readRegA = hit_a ? data_writeReg : arr_a;
   assign data_readRegB = hit_b ? data_writeReg : arr_b;
   assign busyA         = hit_a ? iss_a : raw_busy_a;
   assign busyB         = hit_b ? iss_b : raw_busy_b;
`else
   assign data_readRegA = arr_a;
   assign data_readRegB = arr_b;
   assign busyA         = raw_busy_a;
   assign busyB         = raw_busy_b;
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus with a queue of expected read-port results.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_scoreboard;

   logic        clock;
   logic        clear;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [31:0] data_readRegA;
   logic [31:0] data_readRegB;
   logic        issue_en;
   logic [4:0]  issue_reg;
   logic        busyA;
   logic        busyB;
   logic [5:0]  busy_count;

   typedef struct {
      string       tag;
      logic [31:0] da;
      logic [31:0] db;
      logic        ba;
      logic        bb;
      logic [5:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   regfile_scoreboard dut (
      .clock            (clock),
      .clear            (clear),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .data_readRegA    (data_readRegA),
      .data_readRegB    (data_readRegB),
      .issue_en         (issue_en),
      .issue_reg        (issue_reg),
      .busyA            (busyA),
      .busyB            (busyB),
      .busy_count       (busy_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      clear            = 1'b0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      issue_en         = 1'b0;
      issue_reg        = '0;
   endtask

   // point the read ports, queue the expectation, then pop and compare once settled
   task automatic look(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] da, input logic [31:0] db,
                       input logic ba, input logic bb, input logic [5:0] cnt);
      exp_t e;
      ctrl_readRegA = a;
      ctrl_readRegB = b;
      sb.push_back('{tag, da, db, ba, bb, cnt});
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".dA"}, data_readRegA, e.da);
         chk({e.tag, ".dB"}, data_readRegB, e.db);
         chk({e.tag, ".bA"}, {31'd0, busyA}, {31'd0, e.ba});
         chk({e.tag, ".bB"}, {31'd0, busyB}, {31'd0, e.bb});
         chk({e.tag, ".cnt"}, {26'd0, busy_count}, {26'd0, e.cnt});
      end
   endtask

   initial begin
      logic [31:0] byp;
      idle();
      ctrl_readRegA = '0;
      ctrl_readRegB = '0;
      clear = 1'b1;
      tick();
      tick();
      clear = 1'b0;
      for (int i = 0; i < 32; i++) begin
         look("reset", 5'(i), 5'(31 - i), 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
      end

      // write r5, same-cycle view depends on bypass
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd5;
      data_writeReg    = 32'hDEADBEEF;
`ifdef REGFILE_BYPASS_EN
      byp = 32'hDEADBEEF;
`else
      byp = 32'd0;
`endif
      look("wr5_same", 5'd5, 5'd5, byp, byp, 1'b0, 1'b0, 6'd0);
      tick();
      idle();
      look("wr5_next", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);

      // r0 ignores both write and issue
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd0;
      data_writeReg    = 32'h12345678;
      issue_en         = 1'b1;
      issue_reg        = 5'd0;
      tick();
      idle();
      look("r0", 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);

      // issue then writeback r7
      issue_en  = 1'b1;
      issue_reg = 5'd7;
      tick();
      idle();
      look("iss7", 5'd7, 5'd5, 32'd0, 32'hDEADBEEF, 1'b1, 1'b0, 6'd1);
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd7;
      data_writeReg    = 32'hA5A5A5A5;
      tick();
      idle();
      look("wb7", 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 6'd0);

      // re-issue beats same-cycle writeback
      issue_en  = 1'b1;
      issue_reg = 5'd9;
      tick();
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd9;
      data_writeReg    = 32'h1;
      tick();
      idle();
      look("iss_wb9", 5'd9, 5'd0, 32'h1, 32'd0, 1'b1, 1'b0, 6'd1);

      // free r9, busy r4, then issue r3 while writing back r4
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd9;
      data_writeReg    = 32'h2;
      tick();
      idle();
      look("wb9", 5'd9, 5'd9, 32'h2, 32'h2, 1'b0, 1'b0, 6'd0);
      issue_en  = 1'b1;
      issue_reg = 5'd4;
      tick();
      issue_reg        = 5'd3;
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd4;
      data_writeReg    = 32'h44;
      tick();
      idle();
      look("net0", 5'd3, 5'd4, 32'd0, 32'h44, 1'b1, 1'b0, 6'd1);

      // populate r1..r3 with data, then make all three busy
      for (int i = 1; i <= 3; i++) begin
         ctrl_writeEnable = 1'b1;
         ctrl_writeReg    = 5'(i);
         data_writeReg    = 32'(i * 17);
         tick();
      end
      idle();
      for (int i = 1; i <= 3; i++) begin
         issue_en  = 1'b1;
         issue_reg = 5'(i);
         tick();
      end
      idle();
      look("busy123", 5'd1, 5'd2, 32'd17, 32'd34, 1'b1, 1'b1, 6'd3);

      // clear outranks the same-cycle write and issue
      clear            = 1'b1;
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd1;
      data_writeReg    = 32'hFFFF0000;
      issue_en         = 1'b1;
      issue_reg        = 5'd4;
      tick();
      idle();
      for (int i = 0; i < 32; i++) begin
         look("midclr", 5'(i), 5'(i ^ 5'd1), 32'd0, 32'd0, 1'b0, 1'b0, 6'd0);
      end

      // bypass: write r6 while reading it
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd6;
      data_writeReg    = 32'h55;
`ifdef REGFILE_BYPASS_EN
      byp = 32'h55;
`else
      byp = 32'd0;
`endif
      look("byp6", 5'd6, 5'd0, byp, 32'd0, 1'b0, 1'b0, 6'd0);
      tick();
      idle();
      look("byp6_next", 5'd6, 5'd6, 32'h55, 32'h55, 1'b0, 1'b0, 6'd0);

      // bypassed write with same-cycle issue keeps the register busy
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'd6;
      data_writeReg    = 32'h66;
      issue_en         = 1'b1;
      issue_reg        = 5'd6;
`ifdef REGFILE_BYPASS_EN
      look("byp_iss6", 5'd6, 5'd6, 32'h66, 32'h66, 1'b1, 1'b1, 6'd0);
`else
      look("byp_iss6", 5'd6, 5'd6, 32'h55, 32'h55, 1'b0, 1'b0, 6'd0);
`endif
      tick();
      idle();
      look("iss6_next", 5'd6, 5'd5, 32'h66, 32'd0, 1'b1, 1'b0, 6'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
